encoder: RTL and testbench

ENCODER -- requirements
Module: encoder

---
 rtl/encoder.sv | 113 +++++++++++
 tb/tb_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Rotary quadrature encoder: debounced A/B drive a one-hot LED position (optional ENCODER_SYNC_EN 2-flop input sync).
// led moves 1 clk after debounced A rises (+2 clks with sync); no flow control, every accepted step is applied.
module encoder #(
  parameter int LED_N      = 8,
  parameter int DEBONUCE_N = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic [LED_N-1:0] led
);

  localparam logic [DEBONUCE_N-1:0] CNT_MAX = '1;
  localparam logic [DEBONUCE_N-1:0] CNT_ONE = DEBONUCE_N'(1);

  logic                  a_s, b_s;
  logic                  a_db_q, a_db_d;
  logic                  b_db_q, b_db_d;
  logic [DEBONUCE_N-1:0] a_cnt_q, a_cnt_d;
  logic [DEBONUCE_N-1:0] b_cnt_q, b_cnt_d;
  logic                  a_prev_q, a_prev_d;
  logic [LED_N-1:0]      led_q, led_d;
  logic                  step;

`ifdef ENCODER_SYNC_EN
  logic [1:0] a_sync_q, a_sync_d;
  logic [1:0] b_sync_q, b_sync_d;

  always_comb begin
    a_sync_d = {a_sync_q[0], a};
    b_sync_d = {b_sync_q[0], b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
    end
  end

  assign a_s = a_sync_q[1];
  assign b_s = b_sync_q[1];
`else
  assign a_s = a;
  assign b_s = b;
`endif

  // A new level is accepted on the 2^DEBONUCE_N-th consecutive differing sample.
  always_comb begin
    a_db_d  = a_db_q;
    a_cnt_d = a_cnt_q;
    if (a_s == a_db_q) begin
      a_cnt_d = '0;
    end else if (a_cnt_q == CNT_MAX) begin
      a_db_d  = a_s;
      a_cnt_d = '0;
    end else begin
      a_cnt_d = a_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    b_db_d  = b_db_q;
    b_cnt_d = b_cnt_q;
    if (b_s == b_db_q) begin
      b_cnt_d = '0;
    end else if (b_cnt_q == CNT_MAX) begin
      b_db_d  = b_s;
      b_cnt_d = '0;
    end else begin
      b_cnt_d = b_cnt_q + CNT_ONE;
    end
  end

  assign step = a_db_q & ~a_prev_q;

  always_comb begin
    a_prev_d = a_db_q;
    led_d    = led_q;
    if (step) begin
      if (b_db_q) begin
        led_d = {led_q[0], led_q[LED_N-1:1]};
      end else begin
        led_d = {led_q[LED_N-2:0], led_q[LED_N-1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_db_q   <= 1'b0;
      b_db_q   <= 1'b0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      a_prev_q <= 1'b0;
      led_q    <= LED_N'(1);
    end else begin
      a_db_q   <= a_db_d;
      b_db_q   <= b_db_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      a_prev_q <= a_prev_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: directed reset/CW/CCW/bounce/reset-recovery steps plus random A/B against a position model.
module tb_encoder;

  localparam int LED_N = 8;
  localparam int DB_N  = 2;
  localparam int D     = 2 ** DB_N;
`ifdef ENCODER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int LAT = D + 1 + (SYNC ? 2 : 0);
  localparam logic [31:0] WMASK = (32'd1 << D) - 32'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             a, b;
  logic [LED_N-1:0] led;

  int nchk = 0;
  int nerr = 0;

  encoder #(.LED_N(LED_N), .DEBONUCE_N(DB_N)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .led (led)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last D samples all show it;
  // a step moves the lit position one place, direction chosen by debounced B.
  logic [1:0]  raw_a, raw_b;
  logic [31:0] hist_a, hist_b;
  logic        m_adb, m_bdb, m_adb_prev;
  int          m_pos;
  logic        eff_a, eff_b;
  logic [31:0] nh_a, nh_b;
  logic        m_adb_n, m_bdb_n;
  logic [LED_N-1:0] model_led;

  assign eff_a   = SYNC ? raw_a[1] : a;
  assign eff_b   = SYNC ? raw_b[1] : b;
  assign nh_a    = {hist_a[30:0], eff_a};
  assign nh_b    = {hist_b[30:0], eff_b};
  assign m_adb_n = ((nh_a & WMASK) == WMASK) ? 1'b1 : (((nh_a & WMASK) == 32'd0) ? 1'b0 : m_adb);
  assign m_bdb_n = ((nh_b & WMASK) == WMASK) ? 1'b1 : (((nh_b & WMASK) == 32'd0) ? 1'b0 : m_bdb);
  assign model_led = LED_N'(1) << m_pos;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_a      <= '0;
      raw_b      <= '0;
      hist_a     <= '0;
      hist_b     <= '0;
      m_adb      <= 1'b0;
      m_bdb      <= 1'b0;
      m_adb_prev <= 1'b0;
      m_pos      <= 0;
    end else begin
      raw_a      <= {raw_a[0], a};
      raw_b      <= {raw_b[0], b};
      hist_a     <= nh_a;
      hist_b     <= nh_b;
      m_adb      <= m_adb_n;
      m_bdb      <= m_bdb_n;
      m_adb_prev <= m_adb;
      if (m_adb && !m_adb_prev)
        m_pos <= m_bdb ? (m_pos + LED_N - 1) % LED_N : (m_pos + 1) % LED_N;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model", 32'(led), 32'(model_led));
    chk("onehot", 32'($onehot(led)), 32'd1);
  endtask

  task automatic wait_change(input logic [LED_N-1:0] prev, output int lat);
    lat = 0;
    while (led === prev && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic pulse_a();
    a = 1'b1;
    repeat (10) tick();
    a = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int lat;
    logic [LED_N-1:0] prev;

    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    #1;
    chk("reset_async", 32'(led), 32'h01);
    repeat (3) tick();
    chk("reset_hold", 32'(led), 32'h01);
    rst = 1'b0;
    repeat (100) tick();
    chk("reset_idle", 32'(led), 32'h01);

    // Clockwise: 01,02,...,80,01
    for (int i = 0; i < 8; i++) begin
      prev = led;
      a = 1'b1;
      wait_change(prev, lat);
      chk("cw_lat", 32'(lat), 32'(LAT));
      chk("cw_led", 32'(led), (i == 7) ? 32'h01 : (32'd1 << (i + 1)));
      repeat (10 - lat) tick();
      a = 1'b0;
      repeat (10) tick();
    end

    // Counter-clockwise: 80,40,...,01
    b = 1'b1;
    repeat (10) tick();
    chk("ccw_bset", 32'(led), 32'h01);
    for (int i = 0; i < 8; i++) begin
      prev = led;
      a = 1'b1;
      wait_change(prev, lat);
      chk("ccw_lat", 32'(lat), 32'(LAT));
      chk("ccw_led", 32'(led), 32'd1 << (7 - i));
      repeat (10 - lat) tick();
      a = 1'b0;
      repeat (10) tick();
    end

    for (int i = 0; i < 200; i++) begin
      a = ~a;
      if (i % 2 == 0) b = ~b;
      tick();
    end
    chk("bounce", 32'(led), 32'h01);
    a = 1'b0;
    b = 1'b0;
    repeat (12) tick();
    chk("bounce_settle", 32'(led), 32'h01);

    // Reset in the middle of a debounce at position 4
    repeat (4) pulse_a();
    chk("pre_rst_pos", 32'(led), 32'h10);
    a = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_async", 32'(led), 32'h01);
    a = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("mid_rst_nostep", 32'(led), 32'h01);

    // A held high through reset is accepted afterwards and steps
    a = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_change(8'h01, lat);
    chk("rst_held_lat", 32'(lat), 32'(LAT));
    chk("rst_held_led", 32'(led), 32'h02);
    a = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 150; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
